tilling_buffer_ctrl: RTL
========================

// Module: tilling_buffer_ctrl
// PURPOSE
//  Sequencer for the 4-quadrant tiling buffer (4 SIPO banks; banks 0/1 take the low input half, banks 2/3 the high half).
//  Accepts a valid/ready row stream, steers each row into the correct bank pair and waits for all banks to report full.
//  Presents a complete tile to the downstream engine with a valid/ready handshake, then drains and clears the banks.
//  Sits between the row source (DMA/line fetch) and the tiling buffer plus its tile consumer.
// PARAMETERS
//  SIZE_OF_BUFFER  8    rows per tile; each bank holds SIZE_OF_BUFFER/2 rows; must be even and >=2
//  FULL_TIMEOUT    15   max cycles to wait for bank full/empty flags before raising err_o
//  CNT_W           16   width of tile_cnt_o
// PORTS
//  clk_i         in   1              clock, all logic rising-edge
//  rst_i         in   1              synchronous reset, active-low
//  in_valid_i    in   1              upstream row valid
//  in_ready_o    out  1              controller accepts a row this cycle
//  flush_i       in   1              abort the current tile, clear all banks
//  buf_wr_en_o   out  4              per-bank write enable to the tiling buffer
//  buf_rd_en_o   out  4              per-bank read/clear enable to the tiling buffer
//  buf_empty_i   in   4              per-bank empty flags
//  buf_full_i    in   4              per-bank full flags
//  tile_valid_o  out  1              complete tile available on the buffer read bus
//  tile_ready_i  in   1              downstream consumes the tile
//  row_cnt_o     out  $clog2(SIZE_OF_BUFFER)  rows accepted into the current tile
//  tile_cnt_o    out  CNT_W          tiles delivered since reset (wraps)
//  err_o         out  1              sticky: flag timeout or flag inconsistency
// BEHAVIOUR
//  Reset (rst_i==0 at a clock edge): state=FILL, row_cnt=0, tile_cnt=0, err_o=0; all other outputs 0 (in_ready_o is 1 once state=FILL and flush_i=0).
//  States: FILL -> WAIT_FULL -> PRESENT -> WAIT_EMPTY -> FILL.
//  FILL: in_ready_o = !flush_i. Accept = in_valid_i & in_ready_o.
//   On accept, buf_wr_en_o = 4'b0101 if row_cnt < SIZE_OF_BUFFER/2, else 4'b1010 (combinational, same cycle); row_cnt++.
//   Accept with row_cnt==SIZE_OF_BUFFER-1: row_cnt<=0, go WAIT_FULL.
//  WAIT_FULL: in_ready_o=0; go PRESENT when buf_full_i==4'hF; timer counts cycles; at FULL_TIMEOUT set err_o and still go PRESENT.
//  PRESENT: tile_valid_o=1, held stable until tile_ready_i. On handshake: buf_rd_en_o=4'hF for exactly that cycle, tile_cnt++, go WAIT_EMPTY.
//  WAIT_EMPTY: go FILL when buf_empty_i==4'hF; timeout behaves as in WAIT_FULL (err_o set, proceed to FILL).
//  Consistency: in FILL, if any buf_full_i bit is 1 before its bank pair has received SIZE_OF_BUFFER/2 rows, set err_o.
//  flush_i (any state, highest priority after reset): that cycle no accept, no tile handshake; buf_rd_en_o=4'hF;
//   row_cnt<=0; go WAIT_EMPTY; tile_cnt unchanged. flush_i held high keeps rd_en asserted and state in WAIT_EMPTY.
//  flush_i simultaneous with tile_ready_i in PRESENT: flush wins, tile not counted.
//  buf_wr_en_o and buf_rd_en_o are never both nonzero in the same cycle.
//  tile_cnt_o wraps from 2^CNT_W-1 to 0. err_o is cleared only by reset.
//  Reset mid-tile abandons the tile silently; the buffer is reset by the same rst_i.
// STRUCTURE
//  tilling_pkg.vh: state encodings (FILL=0, WAIT_FULL=1, PRESENT=2, WAIT_EMPTY=3), WR_MASK_TOP=4'b0101,
//   WR_MASK_BOT=4'b1010, ALL_BANKS=4'hF.
//  One 2-bit state register plus row, timer and tile counters; no sub-module. The top level pairs this block with tilling_buffer.
// TESTING
//  1 SIZE_OF_BUFFER=8, 8 back-to-back rows -> wr_en 0101 x4 then 1010 x4; PRESENT after full=F; tile_ready -> rd_en=F one cycle, tile_cnt=1.
//  2 in_valid toggled every other cycle -> wr_en only on accept cycles; row_cnt_o steps 0..7; no extra writes.
//  3 tile_ready held low 20 cycles in PRESENT -> tile_valid_o stays 1, in_ready_o=0, no rd_en; release -> single drain.
//  4 flush_i after 5 rows -> rd_en=F that cycle, row_cnt=0, WAIT_EMPTY, tile_cnt unchanged; next tile restarts with wr_en 0101.
//  5 buf_full_i stuck at 4'h7 after 8 rows -> err_o=1 after FULL_TIMEOUT cycles, tile still presented; err_o stays 1.
//  6 rst_i low mid-PRESENT -> next cycle tile_valid_o=0, tile_cnt_o=0, err_o=0, in_ready_o=1.

Source files
------------

// File: rtl/tilling_buffer_ctrl_pkg.sv
// Shared state encoding and bank masks for the tiling buffer sequencer.
package tilling_buffer_ctrl_pkg;

   typedef enum logic [1:0] {
      FILL       = 2'd0,
      WAIT_FULL  = 2'd1,
      PRESENT    = 2'd2,
      WAIT_EMPTY = 2'd3
   } state_e;

   localparam logic [3:0] WR_MASK_TOP = 4'b0101;
   localparam logic [3:0] WR_MASK_BOT = 4'b1010;
   localparam logic [3:0] ALL_BANKS   = 4'hF;
   localparam logic [3:0] NO_BANKS    = 4'h0;

   // First half of a tile lands in the TOP pair, second half in the BOT pair.
   function automatic logic [3:0] row_wr_mask(input logic first_half);
      return first_half ? WR_MASK_TOP : WR_MASK_BOT;
   endfunction

endpackage

// File: rtl/tilling_buffer_ctrl_if.sv
// Row stream, tile handshake and per-bank buffer control between the sequencer and its neighbours.
interface tilling_buffer_ctrl_if;

   logic       in_valid_i;
   logic       in_ready_o;
   logic       tile_valid_o;
   logic       tile_ready_i;
   logic [3:0] buf_wr_en_o;
   logic [3:0] buf_rd_en_o;
   logic [3:0] buf_empty_i;
   logic [3:0] buf_full_i;

   // slave is the sequencer; master is the row source, tile consumer and bank array together
   modport slave (
      input  in_valid_i, tile_ready_i, buf_empty_i, buf_full_i,
      output in_ready_o, tile_valid_o, buf_wr_en_o, buf_rd_en_o
   );

   modport master (
      output in_valid_i, tile_ready_i, buf_empty_i, buf_full_i,
      input  in_ready_o, tile_valid_o, buf_wr_en_o, buf_rd_en_o
   );

endinterface

// File: rtl/tilling_buffer_ctrl.sv
// Tile sequencer: rows steer into bank pairs the same cycle they are accepted; a full tile is offered
// with valid/ready (held until taken), then banks are drained; flush aborts the tile at any point.
module tilling_buffer_ctrl
   import tilling_buffer_ctrl_pkg::*;
#(
   parameter int SIZE_OF_BUFFER = 8,
   parameter int FULL_TIMEOUT   = 15,
   parameter int CNT_W          = 16
) (
   input  logic                              clk_i,
   input  logic                              rst_i,
   input  logic                              flush_i,
   tilling_buffer_ctrl_if.slave              bus,
   output logic [$clog2(SIZE_OF_BUFFER)-1:0] row_cnt_o,
   output logic [CNT_W-1:0]                  tile_cnt_o,
   output logic                              err_o
);

   localparam int RW = $clog2(SIZE_OF_BUFFER);
   localparam int TW = $clog2(FULL_TIMEOUT + 1);
   localparam logic [RW-1:0] HALF_C   = RW'(SIZE_OF_BUFFER / 2);
   localparam logic [RW-1:0] LAST_C   = RW'(SIZE_OF_BUFFER - 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(FULL_TIMEOUT - 1);

   state_e            state_q, state_d;
   logic [RW-1:0]     row_cnt_q, row_cnt_d;
   logic [TW-1:0]     timer_q, timer_d;
   logic [CNT_W-1:0]  tile_cnt_q, tile_cnt_d;
   logic              err_q, err_d;
   logic              in_rdy;
   logic              timeout;
   logic              early_full;
   logic [3:0]        wr_en, rd_en;

   assign in_rdy     = (state_q == FILL) && !flush_i;
   assign timeout    = (timer_q == TMO_LAST);
   // A pair may only report full once it has received its half of the tile; BOT never completes inside FILL.
   assign early_full = (((bus.buf_full_i & WR_MASK_TOP) != NO_BANKS) && (row_cnt_q < HALF_C))
                     || ((bus.buf_full_i & WR_MASK_BOT) != NO_BANKS);

   always_comb begin
      state_d    = state_q;
      row_cnt_d  = row_cnt_q;
      timer_d    = '0;
      tile_cnt_d = tile_cnt_q;
      err_d      = err_q;
      wr_en      = NO_BANKS;
      rd_en      = NO_BANKS;
      if (flush_i) begin
         rd_en     = ALL_BANKS;
         row_cnt_d = '0;
         state_d   = WAIT_EMPTY;
      end else begin
         case (state_q)
            FILL: begin
               if (early_full) err_d = 1'b1;
               if (bus.in_valid_i && in_rdy) begin
                  wr_en = row_wr_mask(row_cnt_q < HALF_C);
                  if (row_cnt_q == LAST_C) begin
                     row_cnt_d = '0;
                     state_d   = WAIT_FULL;
                  end else begin
                     row_cnt_d = row_cnt_q + RW'(1);
                  end
               end
            end
            WAIT_FULL: begin
               if (bus.buf_full_i == ALL_BANKS) begin
                  state_d = PRESENT;
               end else if (timeout) begin
                  err_d   = 1'b1;
                  state_d = PRESENT;
               end else begin
                  timer_d = timer_q + TW'(1);
               end
            end
            PRESENT: begin
               if (bus.tile_ready_i) begin
                  rd_en      = ALL_BANKS;
                  tile_cnt_d = tile_cnt_q + CNT_W'(1);
                  state_d    = WAIT_EMPTY;
               end
            end
            WAIT_EMPTY: begin
               if (bus.buf_empty_i == ALL_BANKS) begin
                  state_d = FILL;
               end else if (timeout) begin
                  err_d   = 1'b1;
                  state_d = FILL;
               end else begin
                  timer_d = timer_q + TW'(1);
               end
            end
            default: state_d = FILL;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q    <= FILL;
         row_cnt_q  <= '0;
         timer_q    <= '0;
         tile_cnt_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         row_cnt_q  <= row_cnt_d;
         timer_q    <= timer_d;
         tile_cnt_q <= tile_cnt_d;
         err_q      <= err_d;
      end
   end

   assign bus.in_ready_o   = in_rdy;
   assign bus.tile_valid_o = (state_q == PRESENT);
   assign bus.buf_wr_en_o  = wr_en;
   assign bus.buf_rd_en_o  = rd_en;
   assign row_cnt_o        = row_cnt_q;
   assign tile_cnt_o       = tile_cnt_q;
   assign err_o            = err_q;

endmodule
